// File: rtl/apb_sm3_regif.sv
// APB register interface for an SM3 hash core: message/length staging, start/done handshake, hash capture.
// Optional build macro SM3_REGIF_RDBACK_EN: when defined, MSGn and BYTENUM read back their stored values.
module apb_sm3_regif (
    input  logic         io_mainClk,
    input  logic         resetCtrl_systemReset,
    input  logic [11:0]  io_apb_PADDR,
    input  logic         io_apb_PSEL,
    input  logic         io_apb_PENABLE,
    input  logic         io_apb_PWRITE,
    input  logic [31:0]  io_apb_PWDATA,
    output logic [31:0]  io_apb_PRDATA,
    output logic         io_apb_PREADY,
    output logic         io_apb_PSLVERROR,
    output logic         io_SM3_interrupt,
    output logic         core_start,
    output logic [511:0] core_block,
    output logic [31:0]  core_byte_nums,
    output logic [1:0]   core_mode,
    input  logic         core_done,
    input  logic [255:0] core_hash
);
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ADDR_W   = 12;
    localparam int unsigned NUM_MSG  = 16;
    localparam int unsigned NUM_HASH = 8;
    localparam int unsigned IDX_W    = 5;

    localparam logic [ADDR_W-1:0] BASE_ADDR   = 12'h200;
    localparam logic [ADDR_W-1:0] LAST_ADDR   = 12'h264;
    localparam logic [IDX_W-1:0]  IDX_STATUS  = 5'd0;
    localparam logic [IDX_W-1:0]  IDX_MSG0    = 5'd1;
    localparam logic [IDX_W-1:0]  IDX_BYTENUM = 5'd17;
    localparam logic [IDX_W-1:0]  IDX_HASH0   = 5'd18;

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;

    state_t            state_q;
    logic [DATA_W-1:0] msg_q  [NUM_MSG];
    logic [DATA_W-1:0] hash_q [NUM_HASH];
    logic [DATA_W-1:0] bytenum_q;
    logic [DATA_W-1:0] prdata_q;
    logic [1:0]        mode_q;
    logic              go_q;
    logic              start_q;
    logic              irq_q;
    logic              pslverr_q;

    logic              setup_c;
    logic              access_c;
    logic [ADDR_W-1:0] word_c;
    logic [IDX_W-1:0]  idx_c;
    logic [3:0]        msg_idx_c;
    logic [2:0]        hash_idx_c;
    logic              in_range_c;
    logic              is_msg_c;
    logic              is_hash_c;
    logic              err_c;
    logic [DATA_W-1:0] rdata_c;

    // Address decode, evaluated in the setup phase and registered for the access phase
    assign setup_c    = io_apb_PSEL & ~io_apb_PENABLE;
    assign access_c   = io_apb_PSEL & io_apb_PENABLE;
    assign word_c     = (io_apb_PADDR - BASE_ADDR) >> 2;
    assign idx_c      = IDX_W'(word_c);
    assign msg_idx_c  = 4'(idx_c - IDX_MSG0);
    assign hash_idx_c = 3'(idx_c - IDX_HASH0);
    assign in_range_c = (io_apb_PADDR >= BASE_ADDR) && (io_apb_PADDR <= LAST_ADDR)
                        && (io_apb_PADDR[1:0] == 2'b00);
    assign is_msg_c   = (idx_c >= IDX_MSG0) && (idx_c < IDX_BYTENUM);
    assign is_hash_c  = (idx_c >= IDX_HASH0);
    assign err_c      = !in_range_c
                        || (io_apb_PWRITE && (is_hash_c || (state_q == ST_BUSY)));

    // Read mux; bit0 of STATUS is the start request, held until software clears it
    always_comb begin
        rdata_c = '0;
        if (idx_c == IDX_STATUS) begin
            rdata_c = {{(DATA_W-4){1'b0}}, (state_q == ST_DONE), mode_q, go_q};
        end else if (is_msg_c) begin
`ifdef SM3_REGIF_RDBACK_EN
            rdata_c = msg_q[msg_idx_c];
`else
            rdata_c = '0;
`endif
        end else if (idx_c == IDX_BYTENUM) begin
`ifdef SM3_REGIF_RDBACK_EN
            rdata_c = bytenum_q;
`else
            rdata_c = '0;
`endif
        end else if (is_hash_c) begin
            rdata_c = hash_q[hash_idx_c];
        end
    end

    always_ff @(posedge io_mainClk) begin
        if (resetCtrl_systemReset) begin
            state_q   <= ST_IDLE;
            for (int i = 0; i < NUM_MSG; i++)  msg_q[i]  <= '0;
            for (int i = 0; i < NUM_HASH; i++) hash_q[i] <= '0;
            bytenum_q <= '0;
            prdata_q  <= '0;
            mode_q    <= '0;
            go_q      <= 1'b0;
            start_q   <= 1'b0;
            irq_q     <= 1'b0;
            pslverr_q <= 1'b0;
        end else begin
            start_q   <= 1'b0;
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
            if (setup_c) begin
                pslverr_q <= err_c;
                if (!err_c && !io_apb_PWRITE) prdata_q <= rdata_c;
            end
            // Writes commit on the access edge; the registered error already covers BUSY
            if (access_c && io_apb_PWRITE && !pslverr_q) begin
                if (idx_c == IDX_STATUS) begin
                    irq_q <= 1'b0;
                    go_q  <= io_apb_PWDATA[0];
                    if (io_apb_PWDATA[0]) begin
                        mode_q  <= io_apb_PWDATA[2:1];
                        state_q <= ST_BUSY;
                        start_q <= 1'b1;
                    end else begin
                        mode_q  <= '0;
                        state_q <= ST_IDLE;
                    end
                end else if (is_msg_c) begin
                    msg_q[msg_idx_c] <= io_apb_PWDATA;
                end else if (idx_c == IDX_BYTENUM) begin
                    bytenum_q <= io_apb_PWDATA;
                end
            end
            if ((state_q == ST_BUSY) && core_done) begin
                for (int i = 0; i < NUM_HASH; i++) hash_q[i] <= core_hash[DATA_W*i +: DATA_W];
                state_q <= ST_DONE;
                irq_q   <= 1'b1;
            end
        end
    end

    always_comb begin
        core_block = '0;
        for (int i = 0; i < NUM_MSG; i++) core_block[DATA_W*(NUM_MSG-1-i) +: DATA_W] = msg_q[i];
    end

    assign core_byte_nums   = bytenum_q;
    assign core_mode        = mode_q;
    assign core_start       = start_q;
    assign io_SM3_interrupt = irq_q;
    assign io_apb_PRDATA    = prdata_q;
    assign io_apb_PSLVERROR = pslverr_q;
    assign io_apb_PREADY    = io_apb_PSEL & io_apb_PENABLE;
endmodule

// File: tb/tb_apb_sm3_regif.sv
// Scoreboard bench for apb_sm3_regif: APB responses checked against a register-level model.
module tb_apb_sm3_regif;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [11:0]  paddr = '0;
    logic         psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [31:0]  pwdata = '0;
    logic [31:0]  prdata;
    logic         pready, pslverr, irq, core_start;
    logic [511:0] core_block;
    logic [31:0]  core_byte_nums;
    logic [1:0]   core_mode;
    logic         core_done = 1'b0;
    logic [255:0] core_hash = '0;

    localparam logic [255:0] HASH_VAL =
        256'hdebe9ff92275b8a138604889c18e5a4d6fdb70e5387e5765293dcba39c0c5732;

    always #5 clk = ~clk;

    apb_sm3_regif dut (
        .io_mainClk(clk), .resetCtrl_systemReset(rst),
        .io_apb_PADDR(paddr), .io_apb_PSEL(psel), .io_apb_PENABLE(penable),
        .io_apb_PWRITE(pwrite), .io_apb_PWDATA(pwdata),
        .io_apb_PRDATA(prdata), .io_apb_PREADY(pready), .io_apb_PSLVERROR(pslverr),
        .io_SM3_interrupt(irq), .core_start(core_start), .core_block(core_block),
        .core_byte_nums(core_byte_nums), .core_mode(core_mode),
        .core_done(core_done), .core_hash(core_hash)
    );

    // Register-level reference model
    logic [31:0] m_msg [16];
    logic [31:0] m_hash [8];
    logic [31:0] m_bytenum;
    logic [1:0]  m_mode;
    bit          m_go, m_busy, m_done;
    int          exp_starts = 0;

    typedef struct { logic err; logic [31:0] rd; } resp_t;
    resp_t sb [$];

    int n_vec = 0, n_err = 0;
    int pulses = 0, hi_cycles = 0;
    logic start_prev = 1'b0;

    task automatic check(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_msg[i] = '0;
        for (int i = 0; i < 8; i++)  m_hash[i] = '0;
        m_bytenum = '0; m_mode = '0; m_go = 0; m_busy = 0; m_done = 0;
    endtask

    function automatic logic [511:0] m_block();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[511-32*i -: 32] = m_msg[i];
        return b;
    endfunction

    task automatic model_access(input bit wr, input logic [11:0] a, input logic [31:0] d,
                                output logic err, output logic [31:0] rd);
        int i;
        err = (a < 12'h200) || (a > 12'h264) || (a % 4 != 0);
        i   = (int'(a) - 'h200) / 4;
        rd  = '0;
        if (!err && wr && (i >= 18 || m_busy)) err = 1'b1;
        if (err) return;
        if (wr) begin
            if (i == 0) begin
                m_go = d[0]; m_done = 0;
                if (d[0]) begin m_mode = d[2:1]; m_busy = 1; exp_starts++; end
                else m_mode = '0;
            end else if (i <= 16) m_msg[i-1] = d;
            else m_bytenum = d;
        end else begin
            if (i == 0) rd = {28'd0, m_done, m_mode, m_go};
`ifdef SM3_REGIF_RDBACK_EN
            else if (i <= 16) rd = m_msg[i-1];
            else if (i == 17) rd = m_bytenum;
`endif
            else if (i >= 18) rd = m_hash[i-18];
        end
    endtask

    task automatic apb(input bit wr, input logic [11:0] a, input logic [31:0] d);
        resp_t e;
        model_access(wr, a, d, e.err, e.rd);
        if (wr) e.rd = '0;
        sb.push_back(e);
        @(posedge clk); #1 psel = 1; penable = 0; pwrite = wr; paddr = a; pwdata = d;
        @(posedge clk); #1 penable = 1;
        @(posedge clk); #1 psel = 0; penable = 0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst = 1; model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 0;
    endtask

    task automatic wait_done();
        bit seen = 0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk);
            seen = core_done;
        end
        check("core_done_seen", 512'(seen), 512'(1));
    endtask

    // Model SM3 core: answers each start with a done pulse 20 cycles later
    initial begin
        logic [255:0] hv;
        hv = HASH_VAL;
        core_hash = hv;
        forever begin
            @(negedge clk);
            if (core_start) begin
                repeat (20) @(posedge clk);
                #1 core_done = 1;
                if (m_busy) begin
                    m_busy = 0; m_done = 1;
                    for (int i = 0; i < 8; i++) m_hash[i] = hv[32*i +: 32];
                end
                @(posedge clk); #1 core_done = 0;
            end
        end
    end

    // Monitor: pops the scoreboard on every access phase, checks idle bus otherwise
    initial begin
        resp_t e;
        forever begin
            @(negedge clk);
            if (core_start) hi_cycles++;
            if (core_start && !start_prev) pulses++;
            start_prev = core_start;
            if (psel && penable) begin
                if (sb.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL sb_underflow: access at addr %0h with no expected response", paddr);
                end else begin
                    e = sb.pop_front();
                    check($sformatf("apb_resp@%0h", paddr), {pready, pslverr, prdata},
                          {1'b1, e.err, e.rd});
                end
            end else if (prdata !== '0 || pslverr !== 1'b0) begin
                n_vec++; n_err++;
                $display("FAIL idle_bus: prdata %0h pslverr %0b expected 0 0", prdata, pslverr);
            end
        end
    end

    initial begin
        logic [511:0] blk;
        logic [11:0]  a;
        logic [31:0]  d;
        bit           wr;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        check("rst_outputs", {prdata, pslverr, irq, core_start, core_mode, core_byte_nums},
              '0);
        check("rst_block", core_block, '0);

        // Nominal hash flow
        for (int i = 0; i < 16; i++) apb(1, 12'(12'h204 + 4*i), 32'h61626364);
        apb(1, 12'h244, 32'd16);
        apb(1, 12'h200, 32'h1);
        @(negedge clk);
        check("start_pulse_hi", 512'(core_start), 512'(1));
        check("core_block", core_block, m_block());
        check("core_byte_nums", 512'(core_byte_nums), 512'(m_bytenum));
        @(negedge clk);
        check("start_pulse_lo", 512'(core_start), 512'(0));
        wait_done();
        check("irq_at_done", 512'(irq), 512'(0));
        @(negedge clk);
        check("irq_after_done", 512'(irq), 512'(m_done));
        apb(0, 12'h248, 0);
        apb(0, 12'h264, 0);
        apb(0, 12'h200, 0);

        // Clear after completion
        apb(1, 12'h200, 32'h0);
        @(negedge clk);
        check("irq_cleared", 512'(irq), 512'(0));
        apb(0, 12'h200, 0);
        apb(0, 12'h248, 0);
        apb(0, 12'h264, 0);

        // Writes while busy are rejected
        apb(1, 12'h200, 32'h5);
        @(negedge clk);
        check("start2_pulse", 512'(core_start), 512'(1));
        blk = m_block();
        apb(1, 12'h210, 32'hFFFFFFFF);
        apb(1, 12'h200, 32'h1);
        check("busy_block_held", core_block, blk);
        check("busy_mode_held", 512'(core_mode), 512'(2'd2));
        wait_done();
        @(negedge clk);
        apb(0, 12'h200, 0);

        // Illegal accesses
        apb(0, 12'h268, 0);
        apb(1, 12'h24C, 32'hA5A5A5A5);
        apb(0, 12'h202, 0);
        apb(0, 12'h200, 0);
        apb(0, 12'h24C, 0);

        // Readback
        apb(1, 12'h218, 32'h12345678);
        apb(0, 12'h218, 0);
        apb(0, 12'h244, 0);

        // Randomised traffic while not busy (no start requests)
        for (int n = 0; n < 80; n++) begin
            wr = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) < 7) a = 12'(12'h200 + 4*$urandom_range(0, 25));
            else a = 12'($urandom);
            d = $urandom;
            if (wr && a == 12'h200) d[0] = 1'b0;
            apb(wr, a, d);
        end
        check("rand_block", core_block, m_block());
        check("rand_bytenum", 512'(core_byte_nums), 512'(m_bytenum));
        check("rand_mode", 512'(core_mode), 512'(m_mode));

        // Reset in the middle of an operation
        apb(1, 12'h200, 32'h3);
        repeat (5) @(posedge clk);
        do_reset();
        wait_done();
        check("irq_after_rst_done", 512'(irq), 512'(0));
        @(negedge clk);
        check("irq_after_rst_next", 512'(irq), 512'(0));
        apb(0, 12'h200, 0);
        apb(0, 12'h248, 0);
        check("rst_block2", core_block, '0);

        repeat (3) @(negedge clk);
        check("start_pulses", 512'(pulses), 512'(exp_starts));
        check("start_width", 512'(hi_cycles), 512'(exp_starts));
        check("sb_drained", 512'(sb.size()), 512'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/apb_sm3_regif.md
APB_SM3_REGIF -- requirements
Module: apb_sm3_regif

Interface
REQ-001 SHALL have port io_mainClk  input  1  single clock; all logic on its rising edge.
REQ-002 SHALL have port resetCtrl_systemReset  input  1  reset, synchronous, active-high.
REQ-003 SHALL have APB slave ports io_apb_PADDR in 12, io_apb_PSEL in 1, io_apb_PENABLE in 1, io_apb_PWRITE in 1, io_apb_PWDATA in 32.
REQ-004 SHALL have APB response ports io_apb_PRDATA out 32, io_apb_PREADY out 1, io_apb_PSLVERROR out 1.
REQ-005 SHALL have port io_SM3_interrupt  output  1  hash-complete level interrupt.
REQ-006 SHALL have core-side ports core_start out 1 (start pulse), core_block out 512, core_byte_nums out 32, core_mode out 2, core_done in 1 (done pulse), core_hash in 256.

Function
REQ-007 SHALL map registers as follows:
- 0x200 STATUS: bit0 start/busy, bits2:1 mode, bit3 done.
- 0x204..0x240 MSG0..MSG15: MSG0 = core_block[511:480] through MSG15 = core_block[31:0].
- 0x244 BYTENUM.
- 0x248..0x264 HASH0..HASH7, read-only: HASH0 = hash[31:0] through HASH7 = hash[255:224].
REQ-008 SHALL complete each transfer with zero wait states: PREADY = PSEL & PENABLE; register write takes effect on the access-phase edge.
REQ-009 SHALL assert PSLVERROR during the access phase in these cases, with no state change and PRDATA = 0:
- unaligned address;
- address outside 0x200..0x264;
- write to HASHn;
- write to MSGn, BYTENUM or STATUS while BUSY.
REQ-010 SHALL implement FSM IDLE -> BUSY -> DONE -> IDLE.
REQ-011 SHALL, on a STATUS write with bit0 = 1 in IDLE or DONE:
- latch mode;
- clear done and interrupt;
- enter BUSY;
- pulse core_start high for exactly one cycle, the cycle after the access phase.
REQ-012 SHALL, on a STATUS write with bit0 = 0 in IDLE or DONE, clear done, interrupt and mode, and go to IDLE.
REQ-013 SHALL, on core_done in BUSY:
- capture core_hash into HASH0..7 on that edge;
- set done;
- enter DONE;
- assert io_SM3_interrupt from the next cycle until cleared per REQ-011/REQ-012.
REQ-014 SHALL ignore core_done outside BUSY.
REQ-015 SHALL hold core_block, core_byte_nums and core_mode stable while BUSY.
REQ-016 SHALL return {28'b0, done, mode, busy} on a STATUS read.
REQ-017 SHALL make PRDATA valid only during the access phase and 0 otherwise.

Reset
REQ-018 SHALL, on reset, clear the following and force state IDLE, overriding any simultaneous APB write or core_done:
- MSG0..15, BYTENUM, HASH0..7, mode, done;
- core_start, io_SM3_interrupt, PRDATA, PSLVERROR.
REQ-019 SHALL, on reset asserted mid-BUSY, abandon the operation and issue no interrupt for it.

Configuration
REQ-020 SHALL support macro SM3_REGIF_RDBACK_EN:
- defined: MSGn and BYTENUM read back their stored values.
- undefined: reads of MSGn and BYTENUM return 0 without error; all other behaviour unchanged.

Verification
REQ-021 SHALL cover the nominal hash flow:
- stimulus: after reset, write MSG0..15 = 0x61626364, BYTENUM = 16, STATUS = 0x1; model core returns done 20 cycles later with hash 0xdebe9ff92275b8a138604889c18e5a4d6fdb70e5387e5765293dcba39c0c5732;
- response: core_start is one single-cycle pulse; interrupt rises one cycle after done; HASH0 (0x248) reads 0x9c0c5732; HASH7 (0x264) reads 0xdebe9ff9; STATUS reads 0x9.
REQ-022 SHALL cover clear after completion: write STATUS = 0x0 after REQ-021 -> interrupt low next cycle, STATUS reads 0x0, HASH registers retained.
REQ-023 SHALL cover writes while busy: during BUSY write MSG3 = 0xFFFFFFFF and STATUS = 0x1 -> PSLVERROR = 1 on both, core_block unchanged, no second core_start.
REQ-024 SHALL cover illegal accesses: read 0x268, write 0x24C, read 0x202 -> PSLVERROR = 1, PRDATA = 0, no state change.
REQ-025 SHALL cover reset mid-operation: reset asserted in BUSY, then core_done pulses -> interrupt stays 0, STATUS reads 0x0, HASH0 reads 0.
REQ-026 SHALL cover readback under both macro settings: write MSG5 = 0x12345678 -> reads 0x12345678 with SM3_REGIF_RDBACK_EN defined, 0x0 without.
